// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Purpose:
//   Conditions raw, asynchronous board inputs (buttons, reset_n pin, etc.) so
//   that core logic only ever sees clean, synchronous, active-high levels and
//   single-cycle edge pulses. Each channel is independent and runs through:
//     1. optional polarity inversion (active-low pins become active-high)
//     2. a multi-flop synchroniser chain
//     3. a counter-based debouncer that accepts a new level only after it has
//        been seen for debounce_cycles_p consecutive clocks
//     4. registered rise/fall pulse generation on every accepted level change
//
// Parameters:
//   width_p           - number of independent channels
//   sync_depth_p      - synchroniser flops per channel (must be >= 2)
//   debounce_cycles_p - consecutive differing cycles needed to accept a level
//                       (must be >= 1; 1 means "no debounce")
//   invert_p          - per-channel polarity mask, bit=1 inverts that pin
//
// Ports:
//   clk_i          in   1        system clock
//   reset_i        in   1        asynchronous active-high reset; deassertion
//                                is expected to be clock-synchronous
//   async_unsafe_i in   width_p  raw pin levels (unsynchronised, bouncy)
//   level_o        out  width_p  debounced active-high level per channel
//   rise_o         out  width_p  one-cycle pulse on level_o 0->1
//   fall_o         out  width_p  one-cycle pulse on level_o 1->0
//
// Latency:
//   A pin change first captured by sync stage 0 on edge k appears on level_o
//   (with its rise/fall pulse) on edge k + sync_depth_p + debounce_cycles_p - 1.
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int                 width_p           = 4,
  parameter int                 sync_depth_p      = 2,
  parameter int                 debounce_cycles_p = 12000,
  parameter logic [width_p-1:0] invert_p          = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] async_unsafe_i,
  output logic [width_p-1:0] level_o,
  output logic [width_p-1:0] rise_o,
  output logic [width_p-1:0] fall_o
);

  // Counter only ever reaches debounce_cycles_p-1, so this width is enough
  // and saturation can never happen.
  localparam int              cnt_w    = $clog2(debounce_cycles_p + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(debounce_cycles_p - 1);
  localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);

  genvar gi;
  generate
    for (gi = 0; gi < width_p; gi++) begin : g_ch

      logic                    pol;
      logic [sync_depth_p-1:0] sync_reg;
      logic                    s;
      logic [cnt_w-1:0]        cnt_reg;
      logic                    level_reg;
      logic                    rise_reg;
      logic                    fall_reg;

      // Polarity is fixed per channel and folded in ahead of the synchroniser,
      // so everything downstream works purely in active-high terms.
      assign pol = async_unsafe_i[gi] ^ invert_p[gi];

      // Plain shift chain with nothing between stages: stage 0 is the only
      // flop that can go metastable, later stages give it time to resolve.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[sync_depth_p-2:0], pol};
        end
      end

      assign s = sync_reg[sync_depth_p-1];

      // Debounce: count consecutive cycles in which the synchronised input
      // disagrees with the accepted level. A single cycle of agreement clears
      // the count, so any glitch shorter than debounce_cycles_p is dropped.
      // The pulse registers default low and are only raised on the cycle the
      // accepted level actually flips, which makes them exactly one cycle
      // wide and mutually exclusive.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          if (s == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == cnt_last) begin
            cnt_reg   <= '0;
            level_reg <= s;
            rise_reg  <= s;
            fall_reg  <= ~s;
          end else begin
            cnt_reg <= cnt_reg + cnt_one;
          end
        end
      end

      assign level_o[gi] = level_reg;
      assign rise_o[gi]  = rise_reg;
      assign fall_o[gi]  = fall_reg;

    end
  endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Self-checking bench for input_conditioner (width 4, sync depth 2, debounce 4,
// channel 0 inverted). A behavioural model describes the outputs in terms of
// "the last N values the debouncer saw all disagree with the accepted level";
// a compare process checks it against the DUT on every falling edge. Directed
// scenarios add literal expectations at hand-computed cycle offsets, then a
// randomized phase exercises bouncy inputs and asynchronous resets.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int         W   = 4;
  localparam int         D   = 2;
  localparam int         N   = 4;
  localparam logic [3:0] INV = 4'b0001;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [3:0] async_unsafe_i;
  logic [3:0] level_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;

  input_conditioner #(
    .width_p          (W),
    .sync_depth_p     (D),
    .debounce_cycles_p(N),
    .invert_p         (INV)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .async_unsafe_i(async_unsafe_i),
    .level_o       (level_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   pipe_q   : active-high pin samples in flight through the synchroniser;
  //              refilled with D zeros by reset.
  //   seen_log : the last N values presented to the debouncer.
  //   last_evt : edge index of the last reset or accepted change per channel;
  //              only edges after it can form a qualifying window.
  // ---------------------------------------------------------------------------
  logic [3:0] lvl_m, rise_m, fall_m;
  bit         model_valid = 0;
  logic [3:0] pipe_q[$];
  logic [3:0] seen_log[$];
  int         t = 0;
  int         last_evt[4];
  logic [3:0] sv;
  bit         qualify;

  initial begin
    lvl_m = '0; rise_m = '0; fall_m = '0;
    forever begin
      @(posedge clk_i or posedge reset_i);
      if (reset_i) begin
        lvl_m  = '0;
        rise_m = '0;
        fall_m = '0;
        pipe_q.delete();
        for (int i = 0; i < D; i++) pipe_q.push_back(4'b0000);
        for (int c = 0; c < W; c++) last_evt[c] = t;
        model_valid = 1;
      end else if (model_valid) begin
        t++;
        pipe_q.push_back(async_unsafe_i ^ INV);
        sv = pipe_q.pop_front();
        seen_log.push_back(sv);
        if (seen_log.size() > N) void'(seen_log.pop_front());
        rise_m = '0;
        fall_m = '0;
        for (int c = 0; c < W; c++) begin
          qualify = (t - last_evt[c] >= N);
          if (qualify) begin
            for (int j = 0; j < N; j++)
              if (seen_log[j][c] == lvl_m[c]) qualify = 0;
          end
          if (qualify) begin
            lvl_m[c]    = ~lvl_m[c];
            rise_m[c]   = lvl_m[c];
            fall_m[c]   = ~lvl_m[c];
            last_evt[c] = t;
          end
        end
      end
    end
  end

  // Compare process: outputs only change on clk/reset edges, so the falling
  // edge is a stable sampling point.
  initial begin
    forever begin
      @(negedge clk_i);
      if (model_valid) begin
        check("model_level", level_o, lvl_m);
        check("model_rise",  rise_o,  rise_m);
        check("model_fall",  fall_o,  fall_m);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int bounce_val[4] = '{1, 0, 1, 0};
  int bounce_len[4] = '{2, 1, 3, 2};

  initial begin
    reset_i        = 1'b1;
    async_unsafe_i = 4'($urandom);

    // 1. Reset held with random pins: everything stays low.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("rst_level", level_o, 4'b0000);
      check("rst_pulse", rise_o | fall_o, 4'b0000);
      async_unsafe_i = 4'($urandom);
    end

    // 4. Polarity: ch0 pin high (inactive) through reset release.
    async_unsafe_i = 4'b0001;
    @(negedge clk_i);
    reset_i = 1'b0;
    tick(10);
    check("pol_idle_level", level_o, 4'b0000);
    async_unsafe_i[0] = 1'b0;
    tick(5);
    checkb("pol_level_k4", level_o[0], 1'b0);
    tick(1);
    checkb("pol_level_k5", level_o[0], 1'b1);
    checkb("pol_rise_k5",  rise_o[0],  1'b1);
    tick(1);
    checkb("pol_rise_k6",  rise_o[0],  1'b0);

    // 2. Clean press and release on ch1.
    async_unsafe_i[1] = 1'b1;
    tick(5);
    checkb("press_level_k4", level_o[1], 1'b0);
    tick(1);
    checkb("press_level_k5", level_o[1], 1'b1);
    checkb("press_rise_k5",  rise_o[1],  1'b1);
    tick(1);
    checkb("press_rise_k6",  rise_o[1],  1'b0);
    tick(3);
    async_unsafe_i[1] = 1'b0;
    tick(5);
    checkb("rel_level_k4", level_o[1], 1'b1);
    tick(1);
    checkb("rel_level_k5", level_o[1], 1'b0);
    checkb("rel_fall_k5",  fall_o[1],  1'b1);
    tick(1);
    checkb("rel_fall_k6",  fall_o[1],  1'b0);

    // 3. Bounce on ch2, then a stable 1.
    for (int r = 0; r < 4; r++) begin
      async_unsafe_i[2] = bounce_val[r][0];
      for (int k = 0; k < bounce_len[r]; k++) begin
        tick(1);
        checkb("bounce_pulse", rise_o[2] | fall_o[2], 1'b0);
      end
    end
    async_unsafe_i[2] = 1'b1;
    tick(5);
    checkb("bounce_level_k4", level_o[2], 1'b0);
    checkb("bounce_rise_k4",  rise_o[2],  1'b0);
    tick(1);
    checkb("bounce_level_k5", level_o[2], 1'b1);
    checkb("bounce_rise_k5",  rise_o[2],  1'b1);

    // 5. ch1/ch3 rise together, ch2 falls two cycles later.
    tick(3);
    async_unsafe_i[1] = 1'b1;
    async_unsafe_i[3] = 1'b1;
    tick(2);
    async_unsafe_i[2] = 1'b0;
    tick(4);
    check("simul_rise_k5", rise_o, 4'b1010);
    check("simul_fall_k5", fall_o, 4'b0000);
    tick(1);
    check("simul_rise_k6", rise_o, 4'b0000);
    check("simul_fall_k6", fall_o, 4'b0000);
    tick(1);
    check("simul_fall_k7", fall_o, 4'b0100);
    check("simul_rise_k7", rise_o, 4'b0000);
    check("simul_level_k7", level_o, 4'b1011);

    // 6. Mid-operation reset while ch3 is qualifying.
    async_unsafe_i[3] = 1'b0;
    tick(8);
    async_unsafe_i[3] = 1'b1;
    tick(4);
    checkb("midrst_pre_level", level_o[3], 1'b0);
    #2 reset_i = 1'b1;
    #1;
    check("midrst_async_level", level_o, 4'b0000);
    check("midrst_async_pulse", rise_o | fall_o, 4'b0000);
    tick(2);
    reset_i = 1'b0;
    tick(5);
    checkb("midrst_level_k4", level_o[3], 1'b0);
    checkb("midrst_rise_k4",  rise_o[3],  1'b0);
    tick(1);
    checkb("midrst_level_k5", level_o[3], 1'b1);
    checkb("midrst_rise_k5",  rise_o[3],  1'b1);
    tick(1);
    checkb("midrst_rise_k6",  rise_o[3],  1'b0);

    // Randomized phases: fast bounce then slower toggling, with occasional
    // asynchronous resets released on a falling edge.
    for (int ph = 0; ph < 2; ph++) begin
      for (int cyc = 0; cyc < 2500; cyc++) begin
        @(negedge clk_i);
        for (int c = 0; c < W; c++)
          if ($urandom_range(0, (ph == 0) ? 5 : 19) == 0)
            async_unsafe_i[c] = ~async_unsafe_i[c];
        if ($urandom_range(0, 399) == 0) begin
          #2 reset_i = 1'b1;
          @(negedge clk_i);
          reset_i = 1'b0;
        end
      end
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised multi-channel conditioner for raw board inputs such as buttons and the reset_n pin. It generalises the two-flop synchroniser with inverter to N channels and configurable synchroniser depth, adding per-channel polarity, counter-based debounce and one-cycle rise/fall pulses. It sits between the FPGA pins and core logic such as uart_axi, so the core only ever sees clean, synchronous, active-high levels and edges.

Parameters:
width_p, 4, number of independent input channels
sync_depth_p, 2, synchroniser flops per channel (>=2)
debounce_cycles_p, 12000, consecutive stable cycles needed to accept a new level (>=1; 12000 = 1 ms at 12 MHz)
invert_p, 0 (width_p bits), per-channel polarity mask; bit=1 inverts that channel at the input (active-low pins)

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous, active-high reset
async_unsafe_i  input  width_p  raw pin levels: unsynchronised, not debounced
level_o  output  width_p  debounced, synchronous, active-high level per channel
rise_o  output  width_p  one-cycle pulse when level_o goes 0->1
fall_o  output  width_p  one-cycle pulse when level_o goes 1->0

Behaviour:
- Reset (async assert, applied immediately): all sync flops, counters, level_o, rise_o and fall_o go to 0.
- Polarity: per-channel inversion is applied to async_unsafe_i ahead of sync stage 0. pol[i] = async_unsafe_i[i] ^ invert_p[i].
- Synchroniser:
  - Per channel, a chain of sync_depth_p flops: stage0 <= pol, stage k <= stage k-1.
  - s[i] = last stage. No logic between stages.
- Debounce, per channel, counter width $clog2(debounce_cycles_p+1):
  - If s == level_o: cnt <= 0.
  - If s != level_o and cnt == debounce_cycles_p-1: level_o <= s, cnt <= 0.
  - Otherwise (s != level_o): cnt <= cnt+1.
  - Net effect: level_o updates on the Nth consecutive edge where s differs (N = debounce_cycles_p).
  - Any single-cycle agreement of s with level_o restarts the count, so glitches shorter than N cycles are fully rejected.
- Latency: a pin change captured at edge k updates level_o at edge k + sync_depth_p + debounce_cycles_p - 1, i.e. sync_depth_p + debounce_cycles_p edges inclusive.
- Edge pulses:
  - rise_o/fall_o are registered and set on the same edge that level_o changes (rise_o on 0->1, fall_o on 1->0).
  - They are high for exactly one cycle, then cleared.
  - rise_o and fall_o are never both high on one channel. Multiple channels may pulse in the same cycle.
- Channels are fully independent; no cross-channel arbitration.
- debounce_cycles_p = 1: no debounce; level_o follows s one edge later, and pulses still fire.
- Counter saturation cannot occur: cnt is bounded by debounce_cycles_p-1.
- Reset mid-operation:
  - A partially counted transition is discarded.
  - A pending pulse is cleared.
  - After deassert, an input held active re-qualifies from scratch, producing level_o=1 and one rise_o pulse after full latency.
- Reset deassertion is synchronised by the parent (dff/inv/dff chain on channel driving reset_i); this block assumes reset_i deassert is clock-synchronous.

Test Plan:
Bench config for all scenarios: width_p=4, sync_depth_p=2, debounce_cycles_p=4, invert_p=4'b0001.
1. Reset: hold reset_i=1, drive random async_unsafe_i -> level_o=0, rise_o=0, fall_o=0 every cycle. Assert reset_i between edges -> outputs 0 before next edge.
2. Clean press: ch1 0->1 captured at edge k -> level_o[1]=1 at edge k+5. rise_o[1]=1 for that one cycle only. Release -> level_o[1]=0 and a single fall_o[1] pulse, again 6 edges after capture.
3. Bounce rejection: ch2 toggles 1,0,1,0 with runs of 1-3 cycles, then holds 1 -> no pulses during bounce. level_o[2]=1 exactly 6 edges after the final stable 1 is captured.
4. Polarity: ch0 pin held 1 through reset release -> level_o[0] stays 0. Pin driven 0 -> level_o[0]=1 plus rise_o[0] after 6 edges.
5. Simultaneous channels: ch1 and ch3 change on the same edge, ch2 changes 2 cycles later -> ch1/ch3 pulse in the same cycle, ch2 pulses 2 cycles after; no cross-talk.
6. Mid-operation reset: ch3 held 1, reset_i asserted 3 edges after capture, released 2 cycles later with ch3 still 1 -> no pulse before reset. level_o[3]=1 and one rise_o[3] pulse 6 edges after the first post-reset capture.
